// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction sequencer: instruction word layout
// and sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_W = 19;

    localparam int HALT_B  = 18;
    localparam int LOAD_B  = 17;
    localparam int CIN_B   = 16;
    localparam int COUT_B  = 15;
    localparam int OPC_HI  = 14;
    localparam int OPC_LO  = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_GAP,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: synchronous write port, registered read port.
// Array contents are deliberately left unreset; only the read register clears.
module seq_prog_mem
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata_q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [INSTR_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction feeder for the CPU block: fetches commands from a small program
// memory and issues them one ce pulse at a time, paced to the CPU's latency.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int OP_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic [7:0]         cpu_data,
    output logic [6:0]         cpu_opcode,
    output logic               cpu_cin,
    output logic               cpu_cout,
    output logic               cpu_load,
    output logic               cpu_ce
);

    localparam int GAP_W = (OP_GAP > 1) ? $clog2(OP_GAP + 1) : 1;

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [INSTR_W-1:0] instr_q;
    logic               mem_we;
    logic               fetch;
    logic               issue;

    assign mem_we = prog_we && (state_q == S_IDLE);
    assign fetch  = (state_q == S_FETCH);

    seq_prog_mem #(
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (prog_addr),
        .wdata   (prog_wdata),
        .re      (fetch),
        .raddr   (pc_q),
        .rdata_q (instr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                // The last memory word ends the program even without a halt bit.
                if (instr_q[HALT_B] || (&pc_q)) begin
                    state_d = S_DONE;
                end else begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (instr_q[LOAD_B] || (OP_GAP == 0)) begin
                        state_d = S_FETCH;
                    end else begin
                        gap_d   = GAP_W'(OP_GAP);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        issue      = (state_q == S_ISSUE) && !instr_q[HALT_B];
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        pc         = pc_q;
        cpu_ce     = issue;
        cpu_data   = '0;
        cpu_opcode = '0;
        cpu_cin    = 1'b0;
        cpu_cout   = 1'b0;
        cpu_load   = 1'b0;
        if (issue) begin
            cpu_data   = instr_q[DATA_HI:DATA_LO];
            cpu_opcode = instr_q[OPC_HI:OPC_LO];
            cpu_cin    = instr_q[CIN_B];
            cpu_cout   = instr_q[COUT_B];
            cpu_load   = instr_q[LOAD_B];
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: two instances (OP_GAP=2 and OP_GAP=0)
// share stimulus and are compared against a per-program issue-schedule model.
module tb_cpu_sequencer;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int MAXC   = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [18:0] prog_wdata = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;

    logic        busy_a, done_a, ce_a, cin_a, cout_a, load_a;
    logic [3:0]  pc_a;
    logic [7:0]  data_a;
    logic [6:0]  opc_a;
    logic        busy_b, done_b, ce_b, cin_b, cout_b, load_b;
    logic [3:0]  pc_b;
    logic [7:0]  data_b;
    logic [6:0]  opc_b;

    cpu_sequencer #(.ADDR_W(ADDR_W), .OP_GAP(2)) u_dut_gap2 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .abort(abort),
        .busy(busy_a), .done(done_a), .pc(pc_a), .cpu_data(data_a),
        .cpu_opcode(opc_a), .cpu_cin(cin_a), .cpu_cout(cout_a),
        .cpu_load(load_a), .cpu_ce(ce_a)
    );

    cpu_sequencer #(.ADDR_W(ADDR_W), .OP_GAP(0)) u_dut_gap0 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .abort(abort),
        .busy(busy_b), .done(done_b), .pc(pc_b), .cpu_data(data_b),
        .cpu_opcode(opc_b), .cpu_cin(cin_b), .cpu_cout(cout_b),
        .cpu_load(load_b), .cpu_ce(ce_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] prog [DEPTH];
    bit          m_ce  [2][MAXC];
    logic [17:0] m_fld [2][MAXC];
    int          m_done [2];
    int          m_end  [2];
    int          m_pc   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected issue schedule, cycle 0 being the cycle in which start is sampled.
    task automatic build_model(input int d, input int gap, input int kill);
        int t;
        int p;
        logic [18:0] w;
        for (int c = 0; c < MAXC; c++) begin
            m_ce[d][c]  = 1'b0;
            m_fld[d][c] = '0;
        end
        t = 1;
        p = 0;
        while (1'b1) begin
            w = prog[p];
            if (w[18]) begin
                m_done[d] = t + 2;
                break;
            end
            m_ce[d][t+1]  = 1'b1;
            m_fld[d][t+1] = w[17:0];
            if (p == DEPTH - 1) begin
                m_done[d] = t + 2;
                break;
            end
            p++;
            t += w[17] ? 2 : 2 + gap;
        end
        m_pc[d]  = p;
        m_end[d] = m_done[d] + 1;
        if (kill > 0 && kill < m_done[d]) begin
            for (int c = kill + 1; c < MAXC; c++) begin
                m_ce[d][c]  = 1'b0;
                m_fld[d][c] = '0;
            end
            m_done[d] = -1;
            m_end[d]  = kill + 1;
        end
    endtask

    task automatic sample(input int d, output logic ce, output logic [17:0] f,
                          output logic dn, output logic bz, output logic [3:0] p);
        if (d == 0) begin
            ce = ce_a; f = {load_a, cin_a, cout_a, opc_a, data_a};
            dn = done_a; bz = busy_a; p = pc_a;
        end else begin
            ce = ce_b; f = {load_b, cin_b, cout_b, opc_b, data_b};
            dn = done_b; bz = busy_b; p = pc_b;
        end
    endtask

    task automatic check_cycle(input int d, input int c);
        logic ce, dn, bz;
        logic [17:0] f;
        logic [3:0] p;
        string g;
        sample(d, ce, f, dn, bz, p);
        g = $sformatf("gap%0d_cyc%0d", (d == 0) ? 2 : 0, c);
        chk({g, "_ce"},     32'(ce), 32'(m_ce[d][c]));
        chk({g, "_fields"}, 32'(f),  32'(m_fld[d][c]));
        chk({g, "_done"},   32'(dn), 32'(c == m_done[d]));
        chk({g, "_busy"},   32'(bz), 32'(c >= 1 && c < m_end[d]));
        if (c == m_done[d]) chk({g, "_pc"}, 32'(p), 32'(m_pc[d]));
    endtask

    task automatic write_prog();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we    = 1'b1;
            prog_addr  = 4'(i);
            prog_wdata = prog[i];
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
    endtask

    // junk: 0 none, 1 random writes/starts while busy, 2 fixed overwrite of word 1 at cycle 3
    task automatic run_prog(input int kill, input bit kill_rst, input int junk);
        int last;
        int min_end;
        build_model(0, 2, kill);
        build_model(1, 0, kill);
        last    = ((m_end[0] > m_end[1]) ? m_end[0] : m_end[1]) + 1;
        min_end = (m_end[0] < m_end[1]) ? m_end[0] : m_end[1];
        for (int c = 0; c <= last; c++) begin
            check_cycle(0, c);
            check_cycle(1, c);
            if (kill_rst && kill > 0 && c == kill + 1) begin
                chk($sformatf("rst_pc_gap2_cyc%0d", c), 32'(pc_a), 32'd0);
                chk($sformatf("rst_pc_gap0_cyc%0d", c), 32'(pc_b), 32'd0);
            end
            start   = (c == 0);
            abort   = !kill_rst && kill > 0 && c == kill;
            rst     = kill_rst && kill > 0 && c == kill;
            prog_we = 1'b0;
            if (c >= 1 && c < min_end) begin
                if (junk == 1) begin
                    prog_we    = 1'($urandom_range(0, 1));
                    prog_addr  = 4'($urandom_range(0, DEPTH - 1));
                    prog_wdata = 19'($urandom);
                    start      = ($urandom_range(0, 3) == 0);
                end else if (junk == 2 && c == 3) begin
                    prog_we    = 1'b1;
                    prog_addr  = 4'd1;
                    prog_wdata = 19'h4_0000;
                    start      = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        start   = 1'b0;
        abort   = 1'b0;
        rst     = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic check_reset();
        chk("reset_busy", 32'({busy_a, busy_b}), 32'd0);
        chk("reset_done", 32'({done_a, done_b}), 32'd0);
        chk("reset_ce",   32'({ce_a, ce_b}), 32'd0);
        chk("reset_pc",   32'({pc_a, pc_b}), 32'd0);
        chk("reset_cpu_a", 32'({load_a, cin_a, cout_a, opc_a, data_a}), 32'd0);
        chk("reset_cpu_b", 32'({load_b, cin_b, cout_b, opc_b, data_b}), 32'd0);
    endtask

    initial begin
        int kill;
        bit krst;
        @(posedge clk); @(posedge clk); #1;
        check_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset();

        // load then halt
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
        prog[0] = 19'h2_1005;
        prog[1] = 19'h4_0000;
        write_prog();
        run_prog(0, 1'b0, 0);

        // ALU op spacing
        prog[0] = 19'h1_1100;
        prog[1] = 19'h2_20AA;
        prog[2] = 19'h4_0000;
        write_prog();
        run_prog(0, 1'b0, 0);

        // abort in the first gap cycle of the OP_GAP=2 instance
        run_prog(3, 1'b0, 0);

        // prog_we and start ignored while busy
        run_prog(0, 1'b0, 2);
        run_prog(0, 1'b0, 0);

        // no halt anywhere: end of memory terminates
        for (int i = 0; i < DEPTH; i++) prog[i] = 19'h2_0000 | 19'(i * 17);
        write_prog();
        run_prog(0, 1'b0, 0);

        // reset mid-run, memory survives
        run_prog(5, 1'b1, 0);
        run_prog(0, 1'b0, 0);

        for (int r = 0; r < 24; r++) begin
            if (r % 2 == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    prog[i] = 19'($urandom);
                    prog[i][18] = ($urandom_range(0, 9) == 0);
                end
                write_prog();
            end
            build_model(0, 2, 0);
            kill = 0;
            krst = 1'b0;
            if ($urandom_range(0, 2) == 0 && m_done[0] > 2) begin
                kill = $urandom_range(1, m_done[0] - 1);
                krst = ($urandom_range(0, 3) == 0);
            end
            run_prog(kill, krst, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
